// File: rtl/flash_boot_loader_pkg.sv
// Shared types and constants for the flash-to-SRAM boot copier.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package flash_boot_loader_pkg;

    typedef logic [31:0] Word_t;
    typedef logic [15:0] Halfword_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // Default flash source (halfword address) and SRAM destination (byte address).
    localparam Word_t DEF_SRC_BASE = 32'h0000_0000;
    localparam Word_t DEF_DST_BASE = 32'h8000_0000;

endpackage

// File: rtl/flash_boot_loader.sv
// Copies COPY_WORDS 32-bit words from flash (two halfword reads each) into SRAM, then raises boot_done.
// Latency: 2*(1+FLASH_LAT)+1 cycles per word when mem_ack is already high; all outputs registered.
// Backpressure: the SRAM write is held (mem_we, mem_addr, mem_wdata stable) until mem_ack.
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter Word_t SRC_BASE   = DEF_SRC_BASE,
    parameter Word_t DST_BASE   = DEF_DST_BASE,
    parameter Word_t COPY_WORDS = 32'd1024,
    parameter int    FLASH_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fc_addr,
    output logic        fc_read_op,
    input  logic [31:0] fc_data_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        boot_done
);

    // Wait counter value on the cycle the flash data is valid.
    localparam logic [3:0] LAST_CNT = 4'(FLASH_LAT - 1);

    state_t    state_q, state_d;
    Word_t     idx_q, idx_d;
    logic      half_q, half_d;
    logic [3:0] cnt_q, cnt_d;
    Halfword_t lo_q, lo_d;
    Halfword_t hi_q, hi_d;

    Word_t     fc_addr_q, fc_addr_d;
    logic      fc_read_op_q, fc_read_op_d;
    Word_t     mem_addr_q, mem_addr_d;
    Word_t     mem_wdata_q, mem_wdata_d;
    logic      mem_we_q, mem_we_d;
    logic      busy_q, busy_d;
    logic      boot_done_q, boot_done_d;

    // Only the low halfword of the flash bus carries data.
    logic unused_fc_hi;
    assign unused_fc_hi = ^fc_data_read[31:16];

    // Next-state logic; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        fc_addr_d   = fc_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                state_d = (COPY_WORDS == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    if (half_q) begin
                        hi_d    = fc_data_read[15:0];
                        half_d  = 1'b0;
                        state_d = WRITE;
                    end else begin
                        lo_d    = fc_data_read[15:0];
                        half_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    idx_d   = idx_q + 32'd1;
                    state_d = (idx_q + 32'd1 == COPY_WORDS) ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fc_read_op_d = (state_d == ISSUE);
        mem_we_d     = (state_d == WRITE);
        busy_d       = (state_d == ISSUE) || (state_d == WAIT) || (state_d == WRITE);
        boot_done_d  = (state_d == DONE);

        // Address is loaded on entry to ISSUE and then held through WAIT.
        if (state_d == ISSUE) begin
            fc_addr_d = SRC_BASE + {idx_d[30:0], 1'b0} + {31'b0, half_d};
        end
        // idx, hi and lo are frozen in WRITE, so the write stays stable until acked.
        if (state_d == WRITE) begin
            mem_addr_d  = DST_BASE + {idx_d[29:0], 2'b00};
            mem_wdata_d = {hi_d, lo_d};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            half_q       <= 1'b0;
            cnt_q        <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            fc_addr_q    <= '0;
            fc_read_op_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            boot_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            half_q       <= half_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            fc_addr_q    <= fc_addr_d;
            fc_read_op_q <= fc_read_op_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            boot_done_q  <= boot_done_d;
        end
    end

    assign fc_addr    = fc_addr_q;
    assign fc_read_op = fc_read_op_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign boot_done  = boot_done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: five parameterisations run side by side against a flash model and scoreboard.
// Latency: flash model answers exactly FLASH_LAT cycles after each read pulse.
// Backpressure: mem_ack is tied high, held low for a fixed stretch, or randomised per instance.
module tb_flash_boot_loader;

    localparam int NI = 5;
    // 0: two-word reference run   1: zero-length copy   2: source address wrap, minimum latency
    // 3: single word, SRAM stalls 5 cycles   4: destination wrap, maximum latency, random ack
    localparam logic [31:0] SRC_P [NI] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_1230, 32'h0004_0000};
    localparam logic [31:0] DST_P [NI] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h2000_0010, 32'hFFFF_FFF8};
    localparam int          CW_P  [NI] = '{2, 0, 2, 1, 6};
    localparam int          LAT_P [NI] = '{3, 3, 2, 4, 15};

    typedef struct {
        int          off;
        logic        rd;
        logic        we;
        logic        busy;
        logic        done;
        logic        chk_fc;
        logic [31:0] fca;
        logic        chk_mem;
        logic [31:0] ma;
        logic [31:0] md;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fc_addr      [NI];
    logic        fc_read_op   [NI];
    logic [31:0] fc_data_read [NI];
    logic [31:0] mem_addr     [NI];
    logic [31:0] mem_wdata    [NI];
    logic        mem_we       [NI];
    logic        mem_ack      [NI];
    logic        busy         [NI];
    logic        boot_done    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        flash_boot_loader #(
            .SRC_BASE  (SRC_P[g]),
            .DST_BASE  (DST_P[g]),
            .COPY_WORDS(32'(CW_P[g])),
            .FLASH_LAT (LAT_P[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .fc_addr     (fc_addr[g]),
            .fc_read_op  (fc_read_op[g]),
            .fc_data_read(fc_data_read[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_we      (mem_we[g]),
            .mem_ack     (mem_ack[g]),
            .busy        (busy[g]),
            .boot_done   (boot_done[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state: reads and writes seen so far, flash delay line, previous-cycle outputs.
    logic [31:0] pipe_a [NI][16];
    logic        pipe_v [NI][16];
    int          rd_cnt [NI];
    int          wr_cnt [NI];
    int          we_run [NI];
    logic        prev_rd   [NI];
    logic        prev_we   [NI];
    logic        prev_ack  [NI];
    logic        prev_done [NI];
    logic [31:0] prev_ma   [NI];
    logic [31:0] prev_md   [NI];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic all_done();
        logic r = 1'b1;
        for (int g = 0; g < NI; g++) r &= boot_done[g];
        return r;
    endfunction

    // One cycle: observe outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic tick(input logic rst_next);
        logic [31:0] a0, a1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                chk32($sformatf("i%0d reset fc_addr", g), fc_addr[g], 32'h0);
                chk1($sformatf("i%0d reset fc_read_op", g), fc_read_op[g], 1'b0);
                chk32($sformatf("i%0d reset mem_addr", g), mem_addr[g], 32'h0);
                chk32($sformatf("i%0d reset mem_wdata", g), mem_wdata[g], 32'h0);
                chk1($sformatf("i%0d reset mem_we", g), mem_we[g], 1'b0);
                chk1($sformatf("i%0d reset busy", g), busy[g], 1'b0);
                chk1($sformatf("i%0d reset boot_done", g), boot_done[g], 1'b0);
                rd_cnt[g] = 0; wr_cnt[g] = 0; we_run[g] = 0;
                prev_rd[g] = 1'b0; prev_we[g] = 1'b0; prev_ack[g] = 1'b0; prev_done[g] = 1'b0;
                prev_ma[g] = '0; prev_md[g] = '0;
                mem_ack[g] = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    pipe_v[g][j] = 1'b0;
                    pipe_a[g][j] = '0;
                end
                fc_data_read[g] = $urandom;
            end else begin
                if (fc_read_op[g]) begin
                    chk1($sformatf("i%0d read_op back-to-back", g), prev_rd[g], 1'b0);
                    chk1($sformatf("i%0d read count in range", g), rd_cnt[g] < 2 * CW_P[g], 1'b1);
                    chk32($sformatf("i%0d fc_addr of read %0d", g, rd_cnt[g]), fc_addr[g], SRC_P[g] + 32'(rd_cnt[g]));
                    chk1($sformatf("i%0d busy during read", g), busy[g], 1'b1);
                    rd_cnt[g]++;
                end
                if (prev_we[g] && !prev_ack[g]) begin
                    chk1($sformatf("i%0d mem_we held", g), mem_we[g], 1'b1);
                    chk32($sformatf("i%0d mem_addr held", g), mem_addr[g], prev_ma[g]);
                    chk32($sformatf("i%0d mem_wdata held", g), mem_wdata[g], prev_md[g]);
                end
                if (prev_done[g]) begin
                    chk1($sformatf("i%0d boot_done sticky", g), boot_done[g], 1'b1);
                    chk1($sformatf("i%0d busy low when done", g), busy[g], 1'b0);
                    chk1($sformatf("i%0d mem_we low when done", g), mem_we[g], 1'b0);
                    chk1($sformatf("i%0d read_op low when done", g), fc_read_op[g], 1'b0);
                end
                // SRAM acknowledge for the coming edge.
                if (g == 3) begin
                    we_run[g] = mem_we[g] ? we_run[g] + 1 : 0;
                    mem_ack[g] = mem_we[g] && (we_run[g] >= 6);
                end else if (g == 4) begin
                    mem_ack[g] = 1'($urandom_range(0, 1));
                end else begin
                    mem_ack[g] = 1'b1;
                end
                if (mem_we[g]) begin
                    chk1($sformatf("i%0d busy during write", g), busy[g], 1'b1);
                end
                if (mem_we[g] && mem_ack[g]) begin
                    a0 = SRC_P[g] + 32'(2 * wr_cnt[g]);
                    a1 = a0 + 32'd1;
                    chk1($sformatf("i%0d write count in range", g), wr_cnt[g] < CW_P[g], 1'b1);
                    chk32($sformatf("i%0d mem_addr of write %0d", g, wr_cnt[g]), mem_addr[g], DST_P[g] + 32'(4 * wr_cnt[g]));
                    chk32($sformatf("i%0d mem_wdata of write %0d", g, wr_cnt[g]), mem_wdata[g], {a1[15:0], a0[15:0]});
                    if (g == 3) chk32("i3 write held cycles", 32'(we_run[g]), 32'd6);
                    wr_cnt[g]++;
                end
                prev_rd[g]   = fc_read_op[g];
                prev_we[g]   = mem_we[g];
                prev_ack[g]  = mem_ack[g];
                prev_done[g] = boot_done[g];
                prev_ma[g]   = mem_addr[g];
                prev_md[g]   = mem_wdata[g];
                // Flash: data for a read appears FLASH_LAT cycles after the pulse, garbage otherwise.
                for (int j = 15; j > 0; j--) begin
                    pipe_v[g][j] = pipe_v[g][j-1];
                    pipe_a[g][j] = pipe_a[g][j-1];
                end
                pipe_v[g][0] = fc_read_op[g];
                pipe_a[g][0] = fc_addr[g];
                a0 = $urandom;
                if (pipe_v[g][LAT_P[g]])
                    fc_data_read[g] = {a0[31:16], pipe_a[g][LAT_P[g]][15:0]};
                else
                    fc_data_read[g] = a0;
            end
        end
        rst = rst_next;
    endtask

    task automatic run_to_done();
        int n = 0;
        while (!all_done() && n < 2000) begin
            tick(1'b0);
            n++;
        end
        chk1("all copies finish within budget", all_done(), 1'b1);
        for (int g = 0; g < NI; g++) begin
            chk32($sformatf("i%0d total writes", g), 32'(wr_cnt[g]), 32'(CW_P[g]));
            chk32($sformatf("i%0d total reads", g), 32'(rd_cnt[g]), 32'(2 * CW_P[g]));
        end
    endtask

    vec_t tbl [9];

    initial begin
        // Expected outputs of instance 0, indexed by cycles after its first ISSUE.
        tbl[0] = '{0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0};
        tbl[3] = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'h0001_0000};
        tbl[5] = '{9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 32'h0, 32'h0};
        tbl[7] = '{17, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 32'h0003_0002};
        tbl[8] = '{18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};

        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            mem_ack[g] = 1'b1;
            fc_data_read[g] = '0;
        end

        // Run 1: reset, cycle-exact check of instance 0, then all copies to completion.
        repeat (3) tick(1'b1);
        tick(1'b0);
        for (int off = 0; off <= 18; off++) begin
            tick(1'b0);
            if (off == 0) begin
                // One IDLE cycle after the last reset edge, then DONE for the zero-length copy.
                chk1("i1 boot_done second cycle after reset", boot_done[1], 1'b1);
            end
            for (int e = 0; e < 9; e++) begin
                if (tbl[e].off == off) begin
                    chk1($sformatf("i0 t%0d fc_read_op", off), fc_read_op[0], tbl[e].rd);
                    chk1($sformatf("i0 t%0d mem_we", off), mem_we[0], tbl[e].we);
                    chk1($sformatf("i0 t%0d busy", off), busy[0], tbl[e].busy);
                    chk1($sformatf("i0 t%0d boot_done", off), boot_done[0], tbl[e].done);
                    if (tbl[e].chk_fc)
                        chk32($sformatf("i0 t%0d fc_addr", off), fc_addr[0], tbl[e].fca);
                    if (tbl[e].chk_mem) begin
                        chk32($sformatf("i0 t%0d mem_addr", off), mem_addr[0], tbl[e].ma);
                        chk32($sformatf("i0 t%0d mem_wdata", off), mem_wdata[0], tbl[e].md);
                    end
                end
            end
        end
        run_to_done();

        // Run 2: reset during the second word's WAIT of instance 0 (instance 3 is then mid-WRITE).
        repeat (2) tick(1'b1);
        tick(1'b0);
        for (int i = 0; i < 40 && rd_cnt[0] < 3; i++) tick(1'b0);
        chk32("i0 third read reached", 32'(rd_cnt[0]), 32'd3);
        tick(1'b1);
        chk1("i0 in WAIT at reset", busy[0] && !fc_read_op[0] && !mem_we[0], 1'b1);
        chk1("i3 in WRITE at reset", mem_we[3], 1'b1);
        tick(1'b1);
        tick(1'b0);
        run_to_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
